// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_PASS_S = 4'b0000;
  localparam logic [3:0] OP_PASS_R = 4'b0001;
  localparam logic [3:0] OP_INC    = 4'b0010;
  localparam logic [3:0] OP_DEC    = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0101;
  localparam logic [3:0] OP_LSR    = 4'b0110;
  localparam logic [3:0] OP_LSL    = 4'b0111;
  localparam logic [3:0] OP_AND    = 4'b1000;
  localparam logic [3:0] OP_OR     = 4'b1001;
  localparam logic [3:0] OP_XOR    = 4'b1010;
  localparam logic [3:0] OP_NOT    = 4'b1011;
  localparam logic [3:0] OP_NEG    = 4'b1100;
  localparam logic [3:0] OP_MUL    = 4'b1101;
  localparam logic [3:0] OP_ASR    = 4'b1110;
  localparam logic [3:0] OP_ROL    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial-product step per clock.
// done is high during the cycle whose edge performs the final step, and
// product already shows the value that step produces.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH:0]   step_sum;

  assign step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign done     = run_q && (cnt_q == LAST);
  assign product  = {step_sum, lo_q[WIDTH-1:1]};

  // Load operands on start, otherwise add-and-shift the product register each cycle.
  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start) begin
      mcand_d = a;
      hi_d    = '0;
      lo_d    = b;
      cnt_d   = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      hi_d  = step_sum[WIDTH:1];
      lo_d  = {step_sum[0], lo_q[WIDTH-1:1]};
      cnt_d = cnt_q + CW'(1);
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  // Multiplier state registers; reset abandons any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered-output ALU with valid/ready handshakes and an optional
// multi-cycle multiply. Single-cycle ops land on the accepting edge.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v,
  output logic             n,
  output logic             z,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             is_mul_op;
  logic             mul_start;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH:0]   ext;

  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !rst;
  assign accept    = in_valid && in_ready;
  assign is_mul_op = (alu_op == OP_MUL) && (MUL_EN != 0);
  assign mul_start = accept && is_mul_op;

  assign y         = y_q;
  assign c         = c_q;
  assign v         = v_q;
  assign n         = y_q[MSB];
  assign z         = (y_q == '0);
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_MUL);

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (r),
        .b       (s),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // Single-cycle datapath: result and flags from the operands presented this cycle.
  always_comb begin
    alu_y = s;
    alu_c = 1'b0;
    alu_v = 1'b0;
    ext   = '0;
    case (alu_op)
      OP_PASS_S: alu_y = s;
      OP_PASS_R: alu_y = r;
      OP_INC: begin
        ext   = {1'b0, s} + (WIDTH+1)'(1);
        alu_y = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = !s[MSB] && alu_y[MSB];
      end
      OP_DEC: begin
        ext   = {1'b0, s} - (WIDTH+1)'(1);
        alu_y = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = s[MSB] && !alu_y[MSB];
      end
      OP_ADD: begin
        ext   = {1'b0, r} + {1'b0, s};
        alu_y = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = (r[MSB] == s[MSB]) && (alu_y[MSB] != r[MSB]);
      end
      OP_SUB: begin
        ext   = {1'b0, r} - {1'b0, s};
        alu_y = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = (r[MSB] != s[MSB]) && (alu_y[MSB] != r[MSB]);
      end
      OP_LSR: begin
        alu_y = s >> 1;
        alu_c = s[0];
      end
      OP_LSL: begin
        alu_y = s << 1;
        alu_c = s[MSB];
      end
      OP_AND: alu_y = r & s;
      OP_OR:  alu_y = r | s;
      OP_XOR: alu_y = r ^ s;
      OP_NOT: alu_y = ~s;
      OP_NEG: begin
        ext   = {(WIDTH+1){1'b0}} - {1'b0, s};
        alu_y = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = s[MSB] && alu_y[MSB];
      end
      OP_MUL: alu_y = s;
      OP_ASR: begin
        alu_y = {s[MSB], s[MSB:1]};
        alu_c = s[0];
      end
      OP_ROL: begin
        alu_y = {s[MSB-1:0], s[MSB]};
        alu_c = s[MSB];
      end
    endcase
  end

  // Controller: result loading, out_valid bookkeeping and IDLE/MUL/HOLD sequencing.
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    c_d         = c_q;
    v_d         = v_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (is_mul_op) begin
            state_d = ST_MUL;
          end else begin
            y_d         = alu_y;
            c_d         = alu_c;
            v_d         = alu_v;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          y_d         = mul_product[MSB:0];
          c_d         = |mul_product[2*WIDTH-1:WIDTH];
          v_d         = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result, flag and state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      y_q         <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      c_q         <= c_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=16: directed vector table,
// multiply/back-pressure/reset sequences, then randomized traffic against a
// transaction-level reference model.
module tb_alu_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] r;
  logic [15:0] s;
  logic [3:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic        c;
  logic        v;
  logic        n;
  logic        z;
  logic        busy;

  int vectors;
  int miscompares;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] ra;
    logic [15:0] sa;
    logic [15:0] ey;
    logic        ec;
    logic        ev;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  logic [17:0] expq[$];

  alu_pipe #(.WIDTH(16), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r         (r),
    .s         (s),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .c         (c),
    .v         (v),
    .n         (n),
    .z         (z),
    .busy      (busy)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result {c, v, y} from the arithmetic meaning of each opcode.
  function automatic logic [17:0] refModel(input logic [3:0] op, input logic [15:0] ra, input logic [15:0] sa);
    int ur, us, sr, ss, res;
    longint prod;
    logic [15:0] ry;
    logic rc, rv;
    ur = ra;
    us = sa;
    sr = $signed(ra);
    ss = $signed(sa);
    ry = sa;
    rc = 1'b0;
    rv = 1'b0;
    case (op)
      4'h0: ry = sa;
      4'h1: ry = ra;
      4'h2: begin res = us + 1; ry = res[15:0]; rc = (res > 65535); rv = (ss + 1 > 32767); end
      4'h3: begin res = us - 1; ry = res[15:0]; rc = (us == 0); rv = (ss - 1 < -32768); end
      4'h4: begin res = ur + us; ry = res[15:0]; rc = (res > 65535); rv = (sr + ss > 32767) || (sr + ss < -32768); end
      4'h5: begin res = ur - us; ry = res[15:0]; rc = (ur < us); rv = (sr - ss > 32767) || (sr - ss < -32768); end
      4'h6: begin ry = sa >> 1; rc = sa[0]; end
      4'h7: begin ry = sa << 1; rc = sa[15]; end
      4'h8: ry = ra & sa;
      4'h9: ry = ra | sa;
      4'hA: ry = ra ^ sa;
      4'hB: ry = ~sa;
      4'hC: begin res = 0 - us; ry = res[15:0]; rc = (us != 0); rv = (0 - ss > 32767); end
      4'hD: begin prod = longint'(ur) * longint'(us); ry = prod[15:0]; rc = ((prod >> 16) != 0); end
      4'hE: begin res = ss >>> 1; ry = res[15:0]; rc = sa[0]; end
      4'hF: begin ry = {sa[14:0], sa[15]}; rc = sa[15]; end
    endcase
    return {rc, rv, ry};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] ra, input logic [15:0] sa,
                               input logic iv, input logic ordy);
    alu_op    = op;
    r         = ra;
    s         = sa;
    in_valid  = iv;
    out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResult(input string tag, input logic [15:0] ey, input logic ec, input logic ev);
    checkOutput({tag, ".y"}, 32'(y), 32'(ey));
    checkOutput({tag, ".c"}, 32'(c), 32'(ec));
    checkOutput({tag, ".v"}, 32'(v), 32'(ev));
    checkOutput({tag, ".n"}, 32'(n), 32'(ey[15]));
    checkOutput({tag, ".z"}, 32'(z), 32'(ey == 16'h0000));
  endtask

  task automatic checkReset(input string tag);
    checkResult(tag, 16'h0000, 1'b0, 1'b0);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd0);
  endtask

  // Main test sequence.
  initial begin
    logic [17:0] e;
    logic [3:0]  rop;
    logic [15:0] rr, rs;
    vectors     = 0;
    miscompares = 0;

    vecs[0]  = '{4'b0100, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[1]  = '{4'b0101, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    vecs[2]  = '{4'b1110, 16'h0000, 16'h8001, 16'hC000, 1'b1, 1'b0};
    vecs[3]  = '{4'b0010, 16'h0000, 16'h7FFF, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{4'b0010, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{4'b0011, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
    vecs[6]  = '{4'b0011, 16'h0000, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    vecs[7]  = '{4'b1100, 16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1};
    vecs[8]  = '{4'b1100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{4'b0110, 16'h0000, 16'h0003, 16'h0001, 1'b1, 1'b0};
    vecs[10] = '{4'b0111, 16'h0000, 16'h8001, 16'h0002, 1'b1, 1'b0};
    vecs[11] = '{4'b1111, 16'h0000, 16'h8001, 16'h0003, 1'b1, 1'b0};
    vecs[12] = '{4'b1000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
    vecs[13] = '{4'b1001, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0};
    vecs[14] = '{4'b1010, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0};
    vecs[15] = '{4'b1011, 16'h0000, 16'h00FF, 16'hFF00, 1'b0, 1'b0};
    vecs[16] = '{4'b0000, 16'h5678, 16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[17] = '{4'b0001, 16'h5678, 16'h1234, 16'h5678, 1'b0, 1'b0};
    vecs[18] = '{4'b0101, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    vecs[19] = '{4'b0100, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1;
    applyStimulus(4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (2) tick();
    checkReset("reset");

    // Release reset mid-cycle; the very next edge must accept.
    rst = 1'b0;
    $display("[TB] directed vector table, back-to-back");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].op, vecs[i].ra, vecs[i].sa, 1'b1, 1'b1);
      #1;
      checkOutput($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
      tick();
      checkResult($sformatf("vec%0d", i), vecs[i].ey, vecs[i].ec, vecs[i].ev);
      checkOutput($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    checkOutput("drain.out_valid", 32'(out_valid), 32'd0);

    $display("[TB] multiply latency");
    applyStimulus(4'b1101, 16'h0100, 16'h0101, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("mul.busy%0d", i), 32'(busy), 32'd1);
      checkOutput($sformatf("mul.in_ready%0d", i), 32'(in_ready), 32'd0);
      checkOutput($sformatf("mul.out_valid%0d", i), 32'(out_valid), 32'd0);
      tick();
    end
    checkOutput("mul.done.out_valid", 32'(out_valid), 32'd1);
    checkOutput("mul.done.busy", 32'(busy), 32'd0);
    checkOutput("mul.done.in_ready", 32'(in_ready), 32'd0);
    checkResult("mul.done", 16'h0100, 1'b1, 1'b0);
    tick();
    checkOutput("mul.consumed.out_valid", 32'(out_valid), 32'd0);
    checkOutput("mul.consumed.in_ready", 32'(in_ready), 32'd1);

    $display("[TB] back-pressure hold then consume-and-accept");
    applyStimulus(4'b0100, 16'h0001, 16'h0002, 1'b1, 1'b0);
    tick();
    checkResult("bp.first", 16'h0003, 1'b0, 1'b0);
    applyStimulus(4'b0001, 16'hABCD, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'd0);
      tick();
      checkResult($sformatf("bp.hold%0d", i), 16'h0003, 1'b0, 1'b0);
      checkOutput($sformatf("bp.out_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp.release.in_ready", 32'(in_ready), 32'd1);
    tick();
    checkResult("bp.second", 16'hABCD, 1'b0, 1'b0);
    checkOutput("bp.second.out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    checkOutput("bp.empty.out_valid", 32'(out_valid), 32'd0);

    $display("[TB] reset during multiply");
    applyStimulus(4'b1101, 16'h1234, 16'h0042, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    checkOutput("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkReset("abort.reset");
    tick();
    checkReset("abort.reset_edge");
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      checkOutput($sformatf("abort.out_valid%0d", i), 32'(out_valid), 32'd0);
      checkOutput($sformatf("abort.busy%0d", i), 32'(busy), 32'd0);
    end

    $display("[TB] randomized traffic");
    for (int cyc = 0; cyc < 500; cyc++) begin
      rop = 4'($urandom_range(0, 15));
      rr  = 16'($urandom);
      rs  = 16'($urandom);
      applyStimulus(rop, rr, rs, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
      #1;
      if (out_valid) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL rand.unexpected: got y=0x%0h with out_valid=1, expected no result", y);
        end else begin
          e = expq[0];
          checkOutput($sformatf("rand%0d.result", cyc), {12'd0, c, v, n, z, y},
                      {12'd0, e[17], e[16], e[15], (e[15:0] == 16'h0000), e[15:0]});
          if (out_ready) begin
            void'(expq.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(refModel(rop, rr, rs));
      end
      tick();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (out_valid) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL drain.unexpected: got y=0x%0h with out_valid=1, expected no result", y);
        end else begin
          e = expq.pop_front();
          checkOutput($sformatf("drain%0d.result", i), {12'd0, c, v, n, z, y},
                      {12'd0, e[17], e[16], e[15], (e[15:0] == 16'h0000), e[15:0]});
        end
      end
      tick();
    end
    checkOutput("drain.pending", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data-path width in bits (>= 4).
REQ-002 Parameter MUL_EN, default 1; 1 = iterative multiply implemented, 0 = op 4'b1101 behaves as pass s.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 r  input  WIDTH  operand r.
REQ-008 s  input  WIDTH  operand s.
REQ-009 alu_op  input  4  operation select.
REQ-010 out_valid  output  1  result registers hold a result not yet consumed.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 y  output  WIDTH  registered result.
REQ-013 c  output  1  registered carry/borrow/shift-out flag.
REQ-014 v  output  1  registered signed-overflow flag.
REQ-015 n  output  1  registered negative flag, y[WIDTH-1].
REQ-016 z  output  1  registered zero flag, 1 when y is all zeros.
REQ-017 busy  output  1  high while a multiply is iterating.

Function
REQ-018 Ops 0000-1100 SHALL keep legacy semantics at width WIDTH: pass s, pass r, s+1, s-1, r+s, r-s, logical shift right s (c=s[0]), logical shift left s (c=s[MSB]), and, or, xor, not s, 0-s; c = carry-out (bit WIDTH) of the WIDTH+1-bit arithmetic result; c=0 for pass/logic ops.
REQ-019 Op 1110 SHALL be arithmetic shift right of s with c=s[0]; op 1111 SHALL rotate s left by one with c=s[MSB].
REQ-020 Op 1101 SHALL be an unsigned WIDTH x WIDTH multiply; y = low WIDTH bits, c = OR of the high WIDTH bits.
REQ-021 v SHALL be two's-complement overflow for ops 0010, 0011, 0100, 0101 and 1100; v=0 for all other ops.
REQ-022 A transfer in SHALL occur on a rising edge with in_valid && in_ready; operands and op are captured on that edge and may change afterwards.
REQ-023 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !rst.
REQ-024 Single-cycle ops SHALL have latency 1: y/flags updated and out_valid=1 on the accepting edge; back-to-back accepts at one per cycle when out_ready=1.
REQ-025 FSM states IDLE, MUL, HOLD: IDLE -> MUL on accept of op 1101 (MUL_EN=1); MUL iterates one shift-add step per cycle for WIDTH cycles; MUL -> HOLD on the last step with result loaded and out_valid=1; HOLD -> IDLE on out_ready; IDLE stays IDLE on a single-cycle accept.
REQ-026 Multiply latency SHALL be WIDTH+1 edges from accept to out_valid=1; busy=1 exactly in MUL; in_ready=0 in MUL and HOLD.
REQ-027 While out_valid=1 and out_ready=0, y, c, v, n, z SHALL hold stable.
REQ-028 out_valid SHALL clear on an edge with out_ready=1 and no new result loaded; simultaneous consume and accept SHALL load the new result with out_valid staying 1.
REQ-029 n and z SHALL be derived from the registered y, never from unregistered data.
REQ-030 Undefined behaviour excluded: every 4-bit op value is defined by REQ-018 to REQ-020.

Reset
REQ-031 While rst=1: state=IDLE, y=0, c=v=n=0, z=1, out_valid=0, busy=0, in_ready=0.
REQ-032 Reset asserted mid-multiply SHALL abort the operation immediately; no result is delivered after release.
REQ-033 First accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-034 Package alu_pkg SHALL hold the 4-bit opcode constants and the FSM state encoding.
REQ-035 Sub-module alu_mul_seq SHALL implement the iterative shift-add multiplier (start, done, WIDTH parameter); absent when MUL_EN=0.

Verification (WIDTH=16)
REQ-036 Reset release, accept op 0100 r=16'h7FFF s=16'h0001, out_ready=1 -> next cycle y=16'h8000, c=0, v=1, n=1, z=0.
REQ-037 op 0101 r=16'h0000 s=16'h0001 -> y=16'hFFFF, c=1, v=0, n=1; op 1110 s=16'h8001 -> y=16'hC000, c=1.
REQ-038 op 1101 r=16'h0100 s=16'h0101 -> busy for 16 cycles, in_ready=0, out_valid at edge 17: y=16'h0100, c=1.
REQ-039 Hold out_ready=0 after a result, drive new in_valid -> in_ready=0, y/flags unchanged; raise out_ready -> consume and accept in same cycle.
REQ-040 Assert rst at cycle 8 of a multiply -> all outputs at reset values, out_valid never asserts for that op.
